// File: rtl/sm_fifo_pkg.sv
// Shared helpers for the protected synchronous FIFO: width functions, the
// wrapping pointer increment and the error/status pulse struct.
package sm_fifo_pkg;

  function automatic int aw_f(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cw_f(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap at depth-1 so non-power-of-two depths never alias.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int depth);
    if (ptr == 32'(depth - 1)) begin
      return '0;
    end
    return ptr + 32'd1;
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

endpackage

// File: rtl/sm_fifo_mem.sv
// DEPTH x DW flop storage with one synchronous write port and one
// asynchronous read port; contents are intentionally not reset.
module sm_fifo_mem
  import sm_fifo_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int AW    = aw_f(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sm_sync_fifo_prot.sv
// Protected synchronous FIFO: blocked overflow/underflow with pulse flags,
// any depth >= 2, occupancy and threshold flags. Define SYNC_FIFO_FWFT_EN
// for first-word-fall-through reads; default is a registered read port.
module sm_sync_fifo_prot
  import sm_fifo_pkg::*;
#(
  parameter  int DW        = 32,
  parameter  int DEPTH     = 16,
  parameter  int AFULL_TH  = 12,
  parameter  int AEMPTY_TH = 4,
  localparam int AW        = aw_f(DEPTH),
  localparam int CW        = cw_f(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [DW-1:0] data_in,
  input  logic          rd_en,
  output logic [DW-1:0] data_out,
  output logic          rd_valid,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fifo_err_t     err_q, err_d;
  logic          rd_acc;
  logic          wr_acc;
  logic [DW-1:0] mem_rdata;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= CW'(AFULL_TH));
  assign almost_empty = (count_q <= CW'(AEMPTY_TH));
  assign count        = count_q;
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;

  // A write into a full FIFO is legal only when the head leaves in the same cycle.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    err_d.overflow  = wr_en & ~wr_acc;
    err_d.underflow = rd_en & ~rd_acc;
    if (wr_acc) begin
      wr_ptr_d = AW'(ptr_inc(32'(wr_ptr_q), DEPTH));
    end
    if (rd_acc) begin
      rd_ptr_d = AW'(ptr_inc(32'(rd_ptr_q), DEPTH));
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Storage write happens at the same edge the head is read, so a full-FIFO
  // write-through-read still delivers the old word.
  sm_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = mem_rdata;
  assign rd_valid = ~empty;
`else
  logic [DW-1:0] data_out_q, data_out_d;
  logic          rd_valid_q, rd_valid_d;

  always_comb begin
    data_out_d = data_out_q;
    rd_valid_d = rd_acc;
    if (rd_acc) begin
      data_out_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
`endif

`ifndef SYNTHESIS
  a_count_range: assert property (@(posedge clk) disable iff (!rstn)
    count_q <= CW'(DEPTH));
  a_ptrs_range: assert property (@(posedge clk) disable iff (!rstn)
    (32'(wr_ptr_q) < 32'(DEPTH)) && (32'(rd_ptr_q) < 32'(DEPTH)));
`endif

endmodule

// File: tb/tb_sm_sync_fifo_prot.sv
// Randomised and directed bench for sm_sync_fifo_prot (DEPTH 16 and 5)
// against a queue-level occupancy model.
module tb_sm_sync_fifo_prot;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] data_in = '0;

  logic [31:0] dout16, dout5;
  logic        rv16, e16, f16, af16, ae16, ov16, un16;
  logic        rv5, e5, f5, af5, ae5, ov5, un5;
  logic [4:0]  c16;
  logic [2:0]  c5;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  int          m_depth [2] = '{16, 5};
  int          m_afth  [2] = '{12, 4};
  int          m_aeth  [2] = '{4, 1};
  int          m_cnt   [2];
  int          m_head  [2];
  logic [31:0] m_mem   [2][16];
  logic [31:0] m_dout  [2];
  logic        m_rv    [2];
  logic        m_ovf   [2];
  logic        m_udf   [2];

  always #5 clk = ~clk;

  sm_sync_fifo_prot #(.DW(32), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(4)) u16 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout16), .rd_valid(rv16), .empty(e16), .full(f16),
    .almost_full(af16), .almost_empty(ae16), .count(c16),
    .overflow(ov16), .underflow(un16));

  sm_sync_fifo_prot #(.DW(32), .DEPTH(5), .AFULL_TH(4), .AEMPTY_TH(1)) u5 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout5), .rd_valid(rv5), .empty(e5), .full(f5),
    .almost_full(af5), .almost_empty(ae5), .count(c5),
    .overflow(ov5), .underflow(un5));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_head[i] = 0; m_dout[i] = '0;
      m_rv[i] = 1'b0; m_ovf[i] = 1'b0; m_udf[i] = 1'b0;
    end
  endtask

  task automatic model_step(input logic w, input logic r, input logic [31:0] d);
    for (int i = 0; i < 2; i++) begin
      bit ra, wa;
      int tail;
      ra   = r && (m_cnt[i] > 0);
      wa   = w && ((m_cnt[i] < m_depth[i]) || ra);
      tail = (m_head[i] + m_cnt[i]) % m_depth[i];
      m_ovf[i] = w && !wa;
      m_udf[i] = r && !ra;
      m_rv[i]  = ra;
      if (ra) begin
        m_dout[i] = m_mem[i][m_head[i]];
        m_head[i] = (m_head[i] + 1) % m_depth[i];
      end
      if (wa) m_mem[i][tail] = d;
      m_cnt[i] = m_cnt[i] + int'(wa) - int'(ra);
    end
  endtask

  task automatic cmp_inst(input int i, input logic [31:0] dout, input logic rv,
                          input logic e, input logic f, input logic af, input logic ae,
                          input logic [31:0] cnt, input logic ov, input logic un);
    string s;
    s = $sformatf("/D%0d", m_depth[i]);
    chk({"count", s}, cnt, m_cnt[i]);
    chk({"empty", s}, e, m_cnt[i] == 0);
    chk({"full", s}, f, m_cnt[i] == m_depth[i]);
    chk({"almost_full", s}, af, m_cnt[i] >= m_afth[i]);
    chk({"almost_empty", s}, ae, m_cnt[i] <= m_aeth[i]);
    chk({"overflow", s}, ov, m_ovf[i]);
    chk({"underflow", s}, un, m_udf[i]);
`ifdef SYNC_FIFO_FWFT_EN
    chk({"rd_valid", s}, rv, m_cnt[i] > 0);
    if (m_cnt[i] > 0) chk({"data_out", s}, dout, m_mem[i][m_head[i]]);
`else
    chk({"rd_valid", s}, rv, m_rv[i]);
    chk({"data_out", s}, dout, m_dout[i]);
`endif
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, dout16, rv16, e16, f16, af16, ae16, 32'(c16), ov16, un16);
      cmp_inst(1, dout5, rv5, e5, f5, af5, ae5, 32'(c5), ov5, un5);
    end
  end

  task automatic step(input logic w, input logic r, input logic [31:0] d);
    wr_en = w; rd_en = r; data_in = d;
    @(posedge clk);
    if (rstn) model_step(w, r, d);
    #1;
  endtask

  task automatic drain_all();
    for (int n = 0; n < 20 && (m_cnt[0] > 0 || m_cnt[1] > 0); n++) step(1'b0, 1'b1, '0);
    chk("drain_empty", e16, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk_en = 1'b1;
    chk("rst_count", 32'(c16), 0);
    chk("rst_empty", e16, 1);
    chk("rst_aempty", ae16, 1);
    chk("rst_full", f16, 0);
    chk("rst_afull", af16, 0);
    chk("rst_rd_valid", rv16, 0);
    chk("rst_ovf", ov16, 0);
    chk("rst_udf", un16, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_dout", dout16, 0);
`endif
    rstn = 1'b1;

    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 32'(k));
      chk("fill_count", 32'(c16), k + 1);
      chk("fill_afull", af16, (k + 1) >= 12);
      chk("fill_aempty", ae16, (k + 1) <= 4);
    end
    chk("fill_full", f16, 1);

    step(1'b1, 1'b0, 32'h99);
    chk("ovf_pulse", ov16, 1);
    chk("ovf_count", 32'(c16), 16);
    step(1'b1, 1'b1, 32'hAA);
`ifndef SYNC_FIFO_FWFT_EN
    chk("full_rw_data", dout16, 32'h0);
`endif
    chk("full_rw_count", 32'(c16), 16);
    chk("full_rw_ovf", ov16, 0);

    for (int k = 0; k < 16; k++) begin
      exp = (k < 15) ? 32'(k + 1) : 32'hAA;
`ifdef SYNC_FIFO_FWFT_EN
      chk("drain_data", dout16, exp);
      step(1'b0, 1'b1, '0);
`else
      step(1'b0, 1'b1, '0);
      chk("drain_data", dout16, exp);
      chk("drain_rv", rv16, 1);
`endif
      chk("drain_aempty", ae16, (15 - k) <= 4);
      chk("drain_afull", af16, (15 - k) >= 12);
    end
    chk("drained_empty", e16, 1);

    step(1'b1, 1'b1, 32'h77);
    chk("empty_rw_udf", un16, 1);
    chk("empty_rw_count", 32'(c16), 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("empty_rw_rv", rv16, 0);
`endif
    step(1'b0, 1'b1, '0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("empty_rw_data", dout16, 32'h77);
`endif
    chk("empty_rw_udf_clr", un16, 0);

    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h100 + 32'(k));
    for (int k = 0; k < 12; k++) step(1'b1, 1'b1, 32'h110 + 32'(k));
    chk("d5_level", 32'(c5), 3);
    drain_all();

    for (int n = 0; n < 800; n++) begin
      int pw;
      pw = ((n / 100) % 2 == 1) ? 30 : 75;
      step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw), $urandom);
    end
    drain_all();

    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 32'h200 + 32'(k));
    chk("pre_rst_count", 32'(c16), 7);
    wr_en = 1'b0;
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("arst_count", 32'(c16), 0);
    chk("arst_count5", 32'(c5), 0);
    chk("arst_empty", e16, 1);
    chk("arst_aempty", ae16, 1);
    chk("arst_full", f16, 0);
    chk("arst_rv", rv16, 0);
    chk("arst_ovf", ov16, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("arst_dout", dout16, 0);
`endif
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step(1'b1, 1'b0, 32'h3C);
    chk("post_rst_count", 32'(c16), 1);
    step(1'b0, 1'b1, '0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("post_rst_data", dout16, 32'h3C);
`endif
    chk("post_rst_empty", e16, 1);

`ifdef SYNC_FIFO_FWFT_EN
    step(1'b1, 1'b0, 32'h55);
    chk("fwft_data", dout16, 32'h55);
    chk("fwft_rv", rv16, 1);
    step(1'b0, 1'b1, '0);
    chk("fwft_rv_clr", rv16, 0);
`endif

    step(1'b0, 1'b0, '0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
